alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one WIDTH-bit ALU (ADD, SUB, AND, equal-select) among PORTS
// requesters.  A round-robin arbiter grants at most one valid request per
// cycle.  The granted request is computed and captured in a one-entry output
// buffer together with the requester id and an (a == b) flag.  The buffer
// honours downstream backpressure and can be popped and refilled in the
// same cycle.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   reset      - asynchronous, active-low reset
//   in_valid   - per-requester request valid            [PORTS]
//   in_ready   - per-requester accept, one-hot or zero   [PORTS]
//   in_op      - opcodes, requester i at [2i+1:2i]       [2*PORTS]
//   in_a/in_b  - operands, requester i at [WIDTH*i +: WIDTH]
//   out_valid  - output buffer holds a result
//   out_ready  - downstream accepts the result this cycle
//   out_id     - index of the requester that produced the result
//   out_data   - ALU result
//   out_eq     - (a == b) for that request
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter  int WIDTH = 4,
    parameter  int PORTS = 4,
    localparam int ID_W  = $clog2(PORTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PORTS-1:0]       in_valid,
    output logic [PORTS-1:0]       in_ready,
    input  logic [2*PORTS-1:0]     in_op,
    input  logic [WIDTH*PORTS-1:0] in_a,
    input  logic [WIDTH*PORTS-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_eq
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;

    // ADD/SUB wrap modulo 2^WIDTH; anything else is the equal-select op.
    function automatic logic [WIDTH-1:0] alu_calc(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op)
            OP_ADD:  alu_calc = a + b;
            OP_SUB:  alu_calc = a - b;
            OP_AND:  alu_calc = a & b;
            default: alu_calc = (a == b) ? b : a;
        endcase
    endfunction

    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_eq_q, out_eq_d;

    logic             can_load;
    logic             grant_found;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W:0]    scan;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             transfer;

    always_comb begin
        // Buffer can accept when empty or being drained this cycle.
        can_load = !out_valid_q || out_ready;

        // Round-robin scan ptr, ptr+1, ... wrapping modulo PORTS.  The extra
        // bit in scan keeps the wrap correct for non-power-of-two PORTS.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < PORTS; k++) begin
            scan = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(PORTS)) begin
                scan = scan - (ID_W+1)'(PORTS);
            end
            if (!grant_found && in_valid[scan[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[ID_W-1:0];
            end
        end

        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_op = in_op[2*i +: 2];
                sel_a  = in_a[WIDTH*i +: WIDTH];
                sel_b  = in_b[WIDTH*i +: WIDTH];
            end
        end

        // Gating with reset keeps in_ready low for the whole reset interval.
        transfer = grant_found && can_load && reset;
        in_ready = transfer ? (PORTS'(1) << grant_idx) : '0;

        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        out_eq_d    = out_eq_q;

        if (transfer) begin
            // Pop and refill in the same cycle leaves out_valid high.
            out_valid_d = 1'b1;
            out_id_d    = grant_idx;
            out_data_d  = alu_calc(sel_op, sel_a, sel_b);
            out_eq_d    = (sel_a == sel_b);
            ptr_d       = (grant_idx == ID_W'(PORTS-1)) ? '0 : grant_idx + 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            out_eq_q    <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            out_eq_q    <= out_eq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_data  = out_data_q;
    assign out_eq    = out_eq_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//
// Self-checking bench for alu_share_arbiter (WIDTH=4, PORTS=4).  Expected
// results are pushed to a scoreboard queue when a transfer is expected and
// popped when the output buffer should present them.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int WIDTH = 4;
    localparam int PORTS = 4;
    localparam int ID_W  = 2;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        logic             eq;
    } res_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [PORTS-1:0]       in_valid;
    logic [PORTS-1:0]       in_ready;
    logic [2*PORTS-1:0]     in_op;
    logic [WIDTH*PORTS-1:0] in_a;
    logic [WIDTH*PORTS-1:0] in_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_W-1:0]        out_id;
    logic [WIDTH-1:0]       out_data;
    logic                   out_eq;

    res_t sb_q[$];
    res_t exp_r;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .out_eq    (out_eq)
    );

    function automatic res_t model(input int p, input logic [1:0] op,
                                   input logic [3:0] a, input logic [3:0] b);
        res_t r;
        int   s;
        case (op)
            2'd0:    s = (int'(a) + int'(b)) % 16;
            2'd1:    s = (int'(a) - int'(b) + 16) % 16;
            2'd2:    s = int'(a & b);
            default: s = (a == b) ? int'(b) : int'(a);
        endcase
        r.id   = p[ID_W-1:0];
        r.data = s[3:0];
        r.eq   = (a == b);
        return r;
    endfunction

    task automatic set_req(input int p, input logic [1:0] op,
                           input logic [3:0] a, input logic [3:0] b);
        in_valid[p]         = 1'b1;
        in_op[2*p +: 2]     = op;
        in_a[WIDTH*p +: WIDTH] = a;
        in_b[WIDTH*p +: WIDTH] = b;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset;
        in_valid  = '1;
        out_ready = 1'b1;
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_id, out_data, out_eq} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b id=%0d d=%h eq=%b, want all zero",
                     out_valid, out_id, out_data, out_eq);
        end
        tests_run++;
        if (in_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_no_accept: got in_ready=%b out_valid=%b want 0000/0",
                     in_ready, out_valid);
        end
        in_valid = '0;
        reset    = 1'b1;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_alu_ops;
        int         port_t[6] = '{0, 2, 1, 3, 3, 3};
        logic [1:0] op_t[6]   = '{2'd0, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2};
        logic [3:0] a_t[6]    = '{4'h7, 4'h2, 4'hF, 4'h9, 4'h3, 4'hC};
        logic [3:0] b_t[6]    = '{4'h5, 4'h5, 4'h3, 4'h9, 4'h9, 4'hA};
        logic [3:0] d_t[6]    = '{4'hC, 4'hD, 4'h2, 4'h9, 4'h3, 4'h8};
        logic       e_t[6]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        res_t       got;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            in_valid  = '0;
            out_ready = 1'b1;
            set_req(port_t[n], op_t[n], a_t[n], b_t[n]);
            #1;
            tests_run++;
            if (in_ready !== (PORTS'(1) << port_t[n])) begin
                tests_failed++;
                $display("FAIL alu_in_ready[%0d]: got %b want %b", n, in_ready,
                         PORTS'(1) << port_t[n]);
            end
            sb_q.push_back('{id: port_t[n][ID_W-1:0], data: d_t[n], eq: e_t[n]});
            @(posedge clk); @(negedge clk);
            in_valid = '0;
            #1;
            got = {out_id, out_data, out_eq};
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL alu_result[%0d]: scoreboard empty", n);
            end else begin
                exp_r = sb_q.pop_front();
                if (out_valid !== 1'b1 || got !== exp_r) begin
                    tests_failed++;
                    $display("FAIL alu_result[%0d]: got v=%b id=%0d d=%h eq=%b want v=1 id=%0d d=%h eq=%b",
                             n, out_valid, out_id, out_data, out_eq, exp_r.id, exp_r.data, exp_r.eq);
                end
            end
        end
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL alu_idle_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_round_robin;
        int   seq_all[6] = '{0, 1, 2, 3, 0, 1};
        int   seq_sub[2] = '{3, 1};
        res_t got;
        @(negedge clk);
        out_ready = 1'b1;
        for (int p = 0; p < PORTS; p++) set_req(p, 2'd0, 4'(p + 1), 4'(p));
        for (int n = 0; n < 8; n++) begin
            int g;
            if (n == 6) begin
                in_valid = 4'b1010;
            end
            g = (n < 6) ? seq_all[n] : seq_sub[n-6];
            #1;
            tests_run++;
            if (in_ready !== (PORTS'(1) << g)) begin
                tests_failed++;
                $display("FAIL rr_grant[%0d]: got %b want %b", n, in_ready, PORTS'(1) << g);
            end
            sb_q.push_back(model(g, 2'd0, 4'(g + 1), 4'(g)));
            @(posedge clk); @(negedge clk);
            if (n == 7) in_valid = '0;
            #1;
            got = {out_id, out_data, out_eq};
            tests_run++;
            if (sb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL rr_result[%0d]: scoreboard empty", n);
            end else begin
                exp_r = sb_q.pop_front();
                if (out_valid !== 1'b1 || got !== exp_r) begin
                    tests_failed++;
                    $display("FAIL rr_result[%0d]: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                             n, out_valid, out_id, out_data, exp_r.id, exp_r.data);
                end
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure;
        res_t got;
        @(negedge clk);
        out_ready = 1'b1;
        set_req(0, 2'd0, 4'h1, 4'h1);
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_first_grant: got %b want 0001", in_ready);
        end
        sb_q.push_back('{id: 2'd0, data: 4'h2, eq: 1'b1});
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        set_req(0, 2'd1, 4'h9, 4'h4);
        #1;
        got = {out_id, out_data, out_eq};
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL bp_first_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (out_valid !== 1'b1 || got !== exp_r) begin
                tests_failed++;
                $display("FAIL bp_first_result: got v=%b id=%0d d=%h eq=%b want v=1 id=%0d d=%h eq=%b",
                         out_valid, out_id, out_data, out_eq, exp_r.id, exp_r.data, exp_r.eq);
            end
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 ||
                {out_id, out_data, out_eq} !== {2'd0, 4'h2, 1'b1}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b id=%0d d=%h eq=%b want 0000/1/0/2/1",
                         c, in_ready, out_valid, out_id, out_data, out_eq);
            end
            @(posedge clk); @(negedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL bp_release_ready: got %b want 0001", in_ready);
        end
        sb_q.push_back(model(0, 2'd1, 4'h9, 4'h4));
        @(posedge clk); @(negedge clk);
        in_valid = '0;
        #1;
        got = {out_id, out_data, out_eq};
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL bp_release_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (out_valid !== 1'b1 || got !== exp_r) begin
                tests_failed++;
                $display("FAIL bp_release_result: got v=%b id=%0d d=%h eq=%b want v=1 id=%0d d=%h eq=%b",
                         out_valid, out_id, out_data, out_eq, exp_r.id, exp_r.data, exp_r.eq);
            end
        end
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h5) begin
            tests_failed++;
            $display("FAIL bp_pop_hold: got v=%b d=%h want v=0 d=5", out_valid, out_data);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid;
        res_t got;
        @(negedge clk);
        out_ready = 1'b1;
        set_req(1, 2'd0, 4'h4, 4'h4);
        #1;
        tests_run++;
        if (in_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL rm_grant1: got %b want 0010", in_ready);
        end
        sb_q.push_back('{id: 2'd1, data: 4'h8, eq: 1'b1});
        @(posedge clk); @(negedge clk);
        in_valid  = '0;
        out_ready = 1'b0;
        #1;
        got = {out_id, out_data, out_eq};
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rm_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (out_valid !== 1'b1 || got !== exp_r) begin
                tests_failed++;
                $display("FAIL rm_result: got v=%b id=%0d d=%h eq=%b want v=1 id=%0d d=%h eq=%b",
                         out_valid, out_id, out_data, out_eq, exp_r.id, exp_r.data, exp_r.eq);
            end
        end
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, out_id, out_data, out_eq} !== 8'h00) begin
            tests_failed++;
            $display("FAIL rm_async_clear: got v=%b id=%0d d=%h eq=%b want all zero",
                     out_valid, out_id, out_data, out_eq);
        end
        for (int p = 0; p < PORTS; p++) set_req(p, 2'd2, 4'(p + 8), 4'hF);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rm_during_reset: got rdy=%b v=%b want 0000/0", in_ready, out_valid);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL rm_first_grant: got %b want 0001", in_ready);
        end
        sb_q.push_back(model(0, 2'd2, 4'h8, 4'hF));
        @(posedge clk); @(negedge clk);
        in_valid = '0;
        #1;
        got = {out_id, out_data, out_eq};
        tests_run++;
        if (sb_q.size() == 0) begin
            tests_failed++;
            $display("FAIL rm_first_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (out_valid !== 1'b1 || got !== exp_r) begin
                tests_failed++;
                $display("FAIL rm_first_result: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         out_valid, out_id, out_data, exp_r.id, exp_r.data);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_random;
        logic [PORTS-1:0] accepted;
        logic [PORTS-1:0] exp_ready;
        int               tb_ptr;
        bit               tb_ov;
        int               g;
        res_t             got;
        @(posedge clk); @(negedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rnd_start: got out_valid=%b want 0", out_valid);
        end
        tb_ptr   = 1;
        tb_ov    = 1'b0;
        accepted = '1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int p = 0; p < PORTS; p++) begin
                if (accepted[p] || !in_valid[p]) begin
                    in_valid[p] = ($urandom_range(0, 2) != 0);
                    in_op[2*p +: 2]        = 2'($urandom_range(0, 3));
                    in_a[WIDTH*p +: WIDTH] = 4'($urandom_range(0, 15));
                    in_b[WIDTH*p +: WIDTH] = ($urandom_range(0, 3) == 0) ?
                                             in_a[WIDTH*p +: WIDTH] : 4'($urandom_range(0, 15));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            g = -1;
            for (int k = 0; k < PORTS; k++) begin
                int idx;
                idx = (tb_ptr + k) % PORTS;
                if (g < 0 && in_valid[idx]) g = idx;
            end
            exp_ready = (g >= 0 && (!tb_ov || out_ready)) ? (PORTS'(1) << g) : '0;
            #1;
            tests_run++;
            if (in_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, in_ready, exp_ready);
            end
            accepted = '0;
            if (exp_ready != '0) begin
                sb_q.push_back(model(g, in_op[2*g +: 2], in_a[WIDTH*g +: WIDTH], in_b[WIDTH*g +: WIDTH]));
                accepted[g] = 1'b1;
                tb_ptr      = (g + 1) % PORTS;
                tb_ov       = 1'b1;
            end else if (out_ready) begin
                tb_ov = 1'b0;
            end
            @(posedge clk); @(negedge clk); #1;
            tests_run++;
            if (out_valid !== tb_ov) begin
                tests_failed++;
                $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, out_valid, tb_ov);
            end
            if (accepted != '0) begin
                got = {out_id, out_data, out_eq};
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rnd_result[%0d]: scoreboard empty", cyc);
                end else begin
                    exp_r = sb_q.pop_front();
                    if (got !== exp_r) begin
                        tests_failed++;
                        $display("FAIL rnd_result[%0d]: got id=%0d d=%h eq=%b want id=%0d d=%h eq=%b",
                                 cyc, out_id, out_data, out_eq, exp_r.id, exp_r.data, exp_r.eq);
                    end
                end
            end
        end
        in_valid = '0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        test_reset();
        test_alu_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
